// File: rtl/axi2per_pkg.sv
// Shared definitions for the AXI-to-peripheral bridge.
//   state_t     : response-channel FSM states
//   RESP_OKAY   : AXI OKAY response code
//   RESP_SLVERR : AXI SLVERR response code
package axi2per_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_PER = 2'b01,
    SEND_R   = 2'b10,
    SEND_B   = 2'b11
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : axi2per_pkg

// File: rtl/axi2per_res_channel.sv
// Response channel of the AXI-to-peripheral bridge.
// Tracks one outstanding transaction. Request fields are latched when a
// request is accepted. The single peripheral response is turned into either
// an AXI R beat (read) or an AXI B response (write). The AXI valid is
// registered and rises one cycle after the peripheral response.
//
// Optional feature: define AXI2PER_RES_ERR_EN to map the peripheral error
// flag (per_master_r_opc_i) to SLVERR. Without it, resp is always OKAY.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   per_master_r_valid_i/opc_i/   peripheral response (valid, error flag,
//   per_master_r_rdata_i          32-bit read data)
//   axi_slave_r_*                 AXI R channel (64-bit data, single beat)
//   axi_slave_b_*                 AXI B channel
//   trans_req_i/we_i/id_i/        transaction request from the request channel
//   trans_add_i/user_i
//   busy_o                        transaction outstanding
//   done_o                        pulses in the cycle an AXI response handshakes
module axi2per_res_channel
  import axi2per_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      per_master_r_valid_i,
  input  logic                      per_master_r_opc_i,
  input  logic [31:0]               per_master_r_rdata_i,

  output logic                      axi_slave_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
  output logic [1:0]                axi_slave_r_resp_o,
  output logic                      axi_slave_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
  input  logic                      axi_slave_r_ready_i,

  output logic                      axi_slave_b_valid_o,
  output logic [1:0]                axi_slave_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
  input  logic                      axi_slave_b_ready_i,

  input  logic                      trans_req_i,
  input  logic                      trans_we_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  input  logic [AXI_USER_WIDTH-1:0] trans_user_i,

  output logic                      busy_o,
  output logic                      done_o
);

  state_t                      state_q;
  logic [AXI_ID_WIDTH-1:0]     id_q;
  logic [AXI_USER_WIDTH-1:0]   user_q;
  logic                        we_q;
  logic                        add2_q;
  logic                        r_valid_q;
  logic                        b_valid_q;
  logic [AXI_DATA_WIDTH-1:0]   data_q;
  logic [1:0]                  resp_q;
  logic [1:0]                  resp_s;

  // Only add[2] selects the 32-bit lane; the other address bits are unused.
  logic                        unused_add_s;
  assign unused_add_s = ^{trans_add_i[AXI_ADDR_WIDTH-1:3], trans_add_i[1:0]};

`ifdef AXI2PER_RES_ERR_EN
  assign resp_s = per_master_r_opc_i ? RESP_SLVERR : RESP_OKAY;
`else
  logic unused_opc_s;
  assign unused_opc_s = per_master_r_opc_i;
  assign resp_s       = RESP_OKAY;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      id_q      <= '0;
      user_q    <= '0;
      we_q      <= 1'b0;
      add2_q    <= 1'b0;
      r_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      data_q    <= '0;
      resp_q    <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (trans_req_i) begin
            id_q    <= trans_id_i;
            user_q  <= trans_user_i;
            we_q    <= trans_we_i;
            add2_q  <= trans_add_i[2];
            state_q <= WAIT_PER;
          end
        end
        WAIT_PER: begin
          if (per_master_r_valid_i) begin
            resp_q <= resp_s;
            if (we_q) begin
              b_valid_q <= 1'b1;
              state_q   <= SEND_B;
            end else begin
              r_valid_q <= 1'b1;
              // The 32-bit word goes to the lane selected by add[2]; the other lane is zero.
              data_q    <= add2_q ? {per_master_r_rdata_i, 32'h0000_0000}
                                  : {32'h0000_0000, per_master_r_rdata_i};
              state_q   <= SEND_R;
            end
          end
        end
        SEND_R: begin
          if (axi_slave_r_ready_i) begin
            r_valid_q <= 1'b0;
            data_q    <= '0;
            resp_q    <= 2'b00;
            id_q      <= '0;
            user_q    <= '0;
            state_q   <= IDLE;
          end
        end
        SEND_B: begin
          if (axi_slave_b_ready_i) begin
            b_valid_q <= 1'b0;
            resp_q    <= 2'b00;
            id_q      <= '0;
            user_q    <= '0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          r_valid_q <= 1'b0;
          b_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Every channel field is forced to zero while its valid is low.
  assign axi_slave_r_valid_o = r_valid_q;
  assign axi_slave_r_data_o  = r_valid_q ? data_q : '0;
  assign axi_slave_r_resp_o  = r_valid_q ? resp_q : 2'b00;
  assign axi_slave_r_last_o  = r_valid_q;
  assign axi_slave_r_id_o    = r_valid_q ? id_q   : '0;
  assign axi_slave_r_user_o  = r_valid_q ? user_q : '0;

  assign axi_slave_b_valid_o = b_valid_q;
  assign axi_slave_b_resp_o  = b_valid_q ? resp_q : 2'b00;
  assign axi_slave_b_id_o    = b_valid_q ? id_q   : '0;
  assign axi_slave_b_user_o  = b_valid_q ? user_q : '0;

  assign busy_o = (state_q != IDLE);
  // done_o is a same-cycle view of the AXI handshake.
  assign done_o = (r_valid_q & axi_slave_r_ready_i) | (b_valid_q & axi_slave_b_ready_i);

endmodule : axi2per_res_channel

// File: tb/tb_axi2per_res_channel.sv
// Directed self-checking bench for axi2per_res_channel.
module tb_axi2per_res_channel;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        per_master_r_valid_i = 1'b0;
  logic        per_master_r_opc_i = 1'b0;
  logic [31:0] per_master_r_rdata_i = 32'h0;
  logic        axi_slave_r_valid_o;
  logic [63:0] axi_slave_r_data_o;
  logic [1:0]  axi_slave_r_resp_o;
  logic        axi_slave_r_last_o;
  logic [2:0]  axi_slave_r_id_o;
  logic [5:0]  axi_slave_r_user_o;
  logic        axi_slave_r_ready_i = 1'b0;
  logic        axi_slave_b_valid_o;
  logic [1:0]  axi_slave_b_resp_o;
  logic [2:0]  axi_slave_b_id_o;
  logic [5:0]  axi_slave_b_user_o;
  logic        axi_slave_b_ready_i = 1'b0;
  logic        trans_req_i = 1'b0;
  logic        trans_we_i = 1'b0;
  logic [2:0]  trans_id_i = 3'h0;
  logic [31:0] trans_add_i = 32'h0;
  logic [5:0]  trans_user_i = 6'h0;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] err_resp;

  axi2per_res_channel dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .per_master_r_valid_i (per_master_r_valid_i),
    .per_master_r_opc_i   (per_master_r_opc_i),
    .per_master_r_rdata_i (per_master_r_rdata_i),
    .axi_slave_r_valid_o  (axi_slave_r_valid_o),
    .axi_slave_r_data_o   (axi_slave_r_data_o),
    .axi_slave_r_resp_o   (axi_slave_r_resp_o),
    .axi_slave_r_last_o   (axi_slave_r_last_o),
    .axi_slave_r_id_o     (axi_slave_r_id_o),
    .axi_slave_r_user_o   (axi_slave_r_user_o),
    .axi_slave_r_ready_i  (axi_slave_r_ready_i),
    .axi_slave_b_valid_o  (axi_slave_b_valid_o),
    .axi_slave_b_resp_o   (axi_slave_b_resp_o),
    .axi_slave_b_id_o     (axi_slave_b_id_o),
    .axi_slave_b_user_o   (axi_slave_b_user_o),
    .axi_slave_b_ready_i  (axi_slave_b_ready_i),
    .trans_req_i          (trans_req_i),
    .trans_we_i           (trans_we_i),
    .trans_id_i           (trans_id_i),
    .trans_add_i          (trans_add_i),
    .trans_user_i         (trans_user_i),
    .busy_o               (busy_o),
    .done_o               (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: present a request for one cycle.
  task automatic start_trans(input logic we, input logic [2:0] id, input logic [31:0] add,
                             input logic [5:0] user);
    trans_req_i  = 1'b1;
    trans_we_i   = we;
    trans_id_i   = id;
    trans_add_i  = add;
    trans_user_i = user;
    @(posedge clk_i); #1;
    trans_req_i  = 1'b0;
  endtask

  // Called at posedge+1 in WAIT_PER: one-cycle peripheral response.
  task automatic per_resp(input logic opc, input logic [31:0] rdata);
    per_master_r_valid_i = 1'b1;
    per_master_r_opc_i   = opc;
    per_master_r_rdata_i = rdata;
    @(posedge clk_i); #1;
    per_master_r_valid_i = 1'b0;
    per_master_r_opc_i   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    {63'h0, busy_o}, 64'h0);
    check({tag, "_rvalid"},  {63'h0, axi_slave_r_valid_o}, 64'h0);
    check({tag, "_bvalid"},  {63'h0, axi_slave_b_valid_o}, 64'h0);
    check({tag, "_rdata"},   axi_slave_r_data_o, 64'h0);
  endtask

  initial begin
`ifdef AXI2PER_RES_ERR_EN
    err_resp = 2'b10;
`else
    err_resp = 2'b00;
`endif
    #12;
    check_idle("reset");
    check("reset_done", {63'h0, done_o}, 64'h0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Read, id=5, add[2]=1 -> upper lane.
    axi_slave_r_ready_i = 1'b1;
    start_trans(1'b0, 3'd5, 32'h0000_1004, 6'h2A);
    check("rd_busy_wait", {63'h0, busy_o}, 64'h1);
    check("rd_rvalid_wait", {63'h0, axi_slave_r_valid_o}, 64'h0);
    per_resp(1'b0, 32'hDEAD_BEEF);
    check("rd_rvalid", {63'h0, axi_slave_r_valid_o}, 64'h1);
    check("rd_data", axi_slave_r_data_o, 64'hDEAD_BEEF_0000_0000);
    check("rd_id", {61'h0, axi_slave_r_id_o}, 64'h5);
    check("rd_user", {58'h0, axi_slave_r_user_o}, 64'h2A);
    check("rd_last", {63'h0, axi_slave_r_last_o}, 64'h1);
    check("rd_resp", {62'h0, axi_slave_r_resp_o}, 64'h0);
    check("rd_done", {63'h0, done_o}, 64'h1);
    check("rd_no_b", {63'h0, axi_slave_b_valid_o}, 64'h0);
    @(posedge clk_i); #1;
    check_idle("rd_after");
    check("rd_after_done", {63'h0, done_o}, 64'h0);

    // Write, id=2, b_ready low for 3 cycles.
    axi_slave_b_ready_i = 1'b0;
    start_trans(1'b1, 3'd2, 32'h0000_0010, 6'h11);
    per_resp(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) axi_slave_b_ready_i = 1'b1;
      #1;
      check($sformatf("wr_bvalid%0d", i), {63'h0, axi_slave_b_valid_o}, 64'h1);
      check($sformatf("wr_id%0d", i), {61'h0, axi_slave_b_id_o}, 64'h2);
      check($sformatf("wr_resp%0d", i), {62'h0, axi_slave_b_resp_o}, 64'h0);
      check($sformatf("wr_user%0d", i), {58'h0, axi_slave_b_user_o}, 64'h11);
      check($sformatf("wr_busy%0d", i), {63'h0, busy_o}, 64'h1);
      check($sformatf("wr_rvalid%0d", i), {63'h0, axi_slave_r_valid_o}, 64'h0);
      check($sformatf("wr_done%0d", i), {63'h0, done_o}, (i == 3) ? 64'h1 : 64'h0);
      @(posedge clk_i); #1;
    end
    axi_slave_b_ready_i = 1'b0;
    check_idle("wr_after");

    // Read with error flag, add[2]=0 -> lower lane.
    start_trans(1'b0, 3'd3, 32'h0000_0000, 6'h01);
    per_resp(1'b1, 32'h1234_5678);
    check("err_data", axi_slave_r_data_o, 64'h0000_0000_1234_5678);
    check("err_resp", {62'h0, axi_slave_r_resp_o}, {62'h0, err_resp});
    @(posedge clk_i); #1;
    check_idle("err_after");

    // Request pulsed in WAIT_PER must be ignored.
    start_trans(1'b0, 3'd1, 32'h0000_0004, 6'h05);
    trans_req_i = 1'b1; trans_we_i = 1'b1; trans_id_i = 3'd7; trans_user_i = 6'h3F;
    @(posedge clk_i); #1;
    trans_req_i = 1'b0;
    check("ign_busy", {63'h0, busy_o}, 64'h1);
    per_resp(1'b0, 32'hA5A5_0001);
    check("ign_rvalid", {63'h0, axi_slave_r_valid_o}, 64'h1);
    check("ign_bvalid", {63'h0, axi_slave_b_valid_o}, 64'h0);
    check("ign_id", {61'h0, axi_slave_r_id_o}, 64'h1);
    check("ign_user", {58'h0, axi_slave_r_user_o}, 64'h05);
    check("ign_data", axi_slave_r_data_o, 64'hA5A5_0001_0000_0000);
    @(posedge clk_i); #1;
    check_idle("ign_after");

    // Reset while in SEND_R, then a fresh read.
    axi_slave_r_ready_i = 1'b0;
    start_trans(1'b0, 3'd6, 32'h0000_0000, 6'h0C);
    per_resp(1'b0, 32'hCAFE_F00D);
    check("rst_pre_rvalid", {63'h0, axi_slave_r_valid_o}, 64'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_idle("rst_async");
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_idle("rst_post");
    axi_slave_r_ready_i = 1'b1;
    start_trans(1'b0, 3'd4, 32'h0000_0000, 6'h02);
    per_resp(1'b0, 32'h0BAD_F00D);
    check("fresh_rvalid", {63'h0, axi_slave_r_valid_o}, 64'h1);
    check("fresh_data", axi_slave_r_data_o, 64'h0000_0000_0BAD_F00D);
    check("fresh_id", {61'h0, axi_slave_r_id_o}, 64'h4);
    check("fresh_done", {63'h0, done_o}, 64'h1);
    @(posedge clk_i); #1;
    check_idle("fresh_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_axi2per_res_channel
